// File: rtl/eth_tx_sched_pkg.sv
// Shared types and 20 MHz timing constants for the 10BASE-T transmit scheduler.
package eth_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2,
    ST_NLP   = 2'd3
  } state_t;

  localparam int ETH_FRAME_CYCLES = 1376;
  localparam int ETH_IFG_CYCLES   = 192;
  localparam int ETH_NLP_PERIOD   = 320000;
  localparam int ETH_NLP_WIDTH    = 2;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module eth_rr_pick
  import eth_tx_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  output logic                    valid,
  output logic [idx_w(NREQ)-1:0]  idx
);

  localparam int IW = idx_w(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                off;
  int                sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    valid = 1'b0;
    off   = 0;
    // Descending scan so the smallest offset from ptr is the one that sticks.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    idx = IW'(sum);
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin scheduler sharing one 10BASE-T transmitter; enforces frame+IFG and sends NLPs when idle.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int FRAME_CYCLES = ETH_FRAME_CYCLES,
  parameter int IFG_CYCLES   = ETH_IFG_CYCLES,
  parameter int NLP_PERIOD   = ETH_NLP_PERIOD,
  parameter int NLP_WIDTH    = ETH_NLP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [idx_w(NREQ)-1:0]  sel,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    nlp
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(FRAME_CYCLES, IFG_CYCLES, NLP_WIDTH);
  localparam int TW = idx_w(NLP_PERIOD);
  localparam logic [TW-1:0] TIMER_MAX = TW'(NLP_PERIOD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   ptr;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  eth_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      timer    <= '0;
      ptr      <= '0;
      grant    <= '0;
      sel      <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      nlp      <= 1'b0;
    end else begin
      grant    <= '0;
      tx_start <= 1'b0;
      if (state != ST_FRAME && timer != TIMER_MAX) timer <= timer + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant    <= NREQ'(1) << pick_idx;
            tx_start <= 1'b1;
            sel      <= pick_idx;
            ptr      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            state    <= ST_FRAME;
            cnt      <= CW'(FRAME_CYCLES - 1);
            busy     <= 1'b1;
            timer    <= '0;
          end else if (timer == TIMER_MAX) begin
            state <= ST_NLP;
            cnt   <= CW'(NLP_WIDTH - 1);
            busy  <= 1'b1;
            nlp   <= 1'b1;
            timer <= '0;
          end
        end
        ST_FRAME: begin
          if (cnt == '0) begin
            if (IFG_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
              cnt   <= CW'(IFG_CYCLES - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_NLP: begin
          // The idle period is counted from the end of the pulse, so hold the timer here.
          timer <= '0;
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            nlp   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched with FRAME=10, IFG=4, NLP_PERIOD=50, NLP_WIDTH=2, NREQ=2.
module tb_eth_tx_sched;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] grant;
  logic [0:0] sel;
  logic       tx_start;
  logic       busy;
  logic       nlp;

  int n_vec;
  int n_bad;
  int dt;
  bit nlp_seen;

  eth_tx_sched #(
    .NREQ(2), .FRAME_CYCLES(10), .IFG_CYCLES(4), .NLP_PERIOD(50), .NLP_WIDTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .tx_start (tx_start),
    .busy     (busy),
    .nlp      (nlp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_tx(input int bound, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
      if (nlp) nlp_seen = 1'b1;
    end while (!tx_start && cycles < bound);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_grant"},    32'(grant),    32'd0);
    chk({tag, "_sel"},      32'(sel),      32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_nlp"},      32'(nlp),      32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    nlp_seen = 1'b0;
    rst = 1'b1;
    req = 2'b00;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Idle link: NLP entry after edge 50, then every 52 edges, two cycles wide.
    for (int k = 1; k <= 160; k++) begin
      step();
      chk("t1_nlp", 32'(nlp), ((k >= 50) && (((k - 50) % 52) < 2)) ? 32'd1 : 32'd0);
      chk("t1_tx_start", 32'(tx_start), 32'd0);
    end

    // Single-cycle request.
    req = 2'b01;
    step();
    chk("t2_tx_start", 32'(tx_start), 32'd1);
    chk("t2_grant", 32'(grant), 32'd1);
    chk("t2_sel", 32'(sel), 32'd0);
    chk("t2_busy0", 32'(busy), 32'd1);
    req = 2'b00;
    for (int i = 1; i <= 13; i++) begin
      step();
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_no_restart", 32'(tx_start), 32'd0);
    end
    step();
    chk("t2_busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t2_no_second_grant", 32'(grant), 32'd0);
    end

    // Both sources held: alternating grants every 15 cycles, no NLP.
    do_reset();
    req = 2'b11;
    nlp_seen = 1'b0;
    wait_tx(20, dt);
    chk("t3_latency", 32'(dt), 32'd1);
    chk("t3_grant0", 32'(grant), 32'd1);
    chk("t3_sel0", 32'(sel), 32'd0);
    for (int g = 1; g <= 3; g++) begin
      wait_tx(30, dt);
      chk("t3_period", 32'(dt), 32'd15);
      chk("t3_grant", 32'(grant), (g % 2 == 1) ? 32'd2 : 32'd1);
      chk("t3_sel", 32'(sel), (g % 2 == 1) ? 32'd1 : 32'd0);
    end
    chk("t3_nlp_seen", 32'(nlp_seen), 32'd0);
    req = 2'b00;

    // Request in the same cycle the timer expires: frame wins, NLP rescheduled.
    do_reset();
    for (int k = 1; k <= 49; k++) step();
    req = 2'b10;
    step();
    chk("t4_tx_start", 32'(tx_start), 32'd1);
    chk("t4_grant", 32'(grant), 32'd2);
    chk("t4_sel", 32'(sel), 32'd1);
    chk("t4_nlp", 32'(nlp), 32'd0);
    req = 2'b00;
    for (int k = 51; k <= 115; k++) begin
      step();
      chk("t4_nlp_sched", 32'(nlp), ((k == 110) || (k == 111)) ? 32'd1 : 32'd0);
      if (k == 63) chk("t4_busy_gap", 32'(busy), 32'd1);
      if (k == 64) chk("t4_busy_idle", 32'(busy), 32'd0);
    end

    // Request raised during an NLP waits for the pulse to finish.
    dt = 0;
    do begin
      step();
      dt++;
    end while (!nlp && dt < 60);
    chk("t5_nlp_wait", 32'(dt), 32'd47);
    req = 2'b01;
    step();
    chk("t5_nlp_hold", 32'(nlp), 32'd1);
    chk("t5_no_start", 32'(tx_start), 32'd0);
    step();
    chk("t5_nlp_fall", 32'(nlp), 32'd0);
    chk("t5_no_start2", 32'(tx_start), 32'd0);
    step();
    chk("t5_tx_start", 32'(tx_start), 32'd1);
    chk("t5_grant", 32'(grant), 32'd1);

    // Reset in the middle of a frame, request held across it.
    req = 2'b10;
    wait_tx(30, dt);
    chk("t6_period", 32'(dt), 32'd15);
    chk("t6_grant", 32'(grant), 32'd2);
    chk("t6_sel", 32'(sel), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk_all_zero("t6_rst");
    rst = 1'b0;
    step();
    chk("t6_regrant_start", 32'(tx_start), 32'd1);
    chk("t6_regrant", 32'(grant), 32'd2);
    chk("t6_regrant_sel", 32'(sel), 32'd1);
    chk("t6_regrant_busy", 32'(busy), 32'd1);
    req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
